// File: rtl/md5_pkg.sv
// Shared MD5 datapath types and constants for the digest transmitter and filter.
// Also carries the nonce generator's state encoding and a digit-to-ASCII helper.
package md5_pkg;

   localparam int         MD5_BLOCK_BYTES = 64;
   localparam int         MD5_LEN_OFFSET  = 56;
   localparam logic [7:0] MD5_PAD_BYTE    = 8'h80;

   typedef logic [511:0] md5_block_t;
   typedef logic [127:0] md5_digest_t;

   typedef enum logic [1:0] {
      GEN_IDLE,
      GEN_RUN,
      GEN_DONE
   } gen_state_t;

   function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
      return {4'h3, d};
   endfunction

endpackage

// File: rtl/nonce_block_gen_bcd_counter.sv
// Variable-width decimal counter starting at 1; grows one digit at a time and
// flags the all-nines value so the owner can stop before it would wrap.
module bcd_counter #(
   parameter int NONCE_DIGITS = 8
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic                                  inc,
   output logic [4*NONCE_DIGITS-1:0]             digits,
   output logic [$clog2(NONCE_DIGITS+1)-1:0]     digit_count,
   output logic                                  overflow
);

   localparam int DW    = 4 * NONCE_DIGITS;
   localparam int CNT_W = $clog2(NONCE_DIGITS + 1);

   logic [DW-1:0]    nxt_digits;
   logic [CNT_W-1:0] nxt_count;
   logic             carry;
   logic             all_nines;

   always_comb begin
      nxt_digits = digits;
      nxt_count  = digit_count;
      carry      = 1'b1;
      for (int i = 0; i < NONCE_DIGITS; i++) begin
         if (carry && (i < int'(digit_count))) begin
            if (digits[4*i +: 4] == 4'd9) begin
               nxt_digits[4*i +: 4] = 4'd0;
            end else begin
               nxt_digits[4*i +: 4] = digits[4*i +: 4] + 4'd1;
               carry                = 1'b0;
            end
         end
      end
      // A carry past the current top digit opens a new leading '1'.
      if (carry && (int'(digit_count) < NONCE_DIGITS)) begin
         for (int i = 0; i < NONCE_DIGITS; i++) begin
            if (i == int'(digit_count)) begin
               nxt_digits[4*i +: 4] = 4'd1;
            end
         end
         nxt_count = digit_count + 1'b1;
      end
   end

   always_comb begin
      all_nines = 1'b1;
      for (int i = 0; i < NONCE_DIGITS; i++) begin
         if (digits[4*i +: 4] != 4'd9) begin
            all_nines = 1'b0;
         end
      end
   end

   assign overflow = all_nines && (digit_count == CNT_W'(NONCE_DIGITS));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         digits      <= DW'(1);
         digit_count <= CNT_W'(1);
      end else if (inc) begin
         digits      <= nxt_digits;
         digit_count <= nxt_count;
      end
   end

endmodule

// File: rtl/nonce_block_gen.sv
// Builds single-block MD5 messages "<key><decimal nonce>" for nonces 1, 2, 3, ...
// and streams them to the MD5 core until a hit is reported or the range runs out.
module nonce_block_gen
   import md5_pkg::*;
#(
   parameter int MAX_KEY_BYTES = 16,
   parameter int NONCE_DIGITS  = 8,
   parameter int NONCE_WIDTH   = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   key_valid,
   input  logic [7:0]             key_data,
   input  logic                   key_last,
   output logic                   key_ready,
   input  logic                   stop,
   output logic                   block_valid,
   input  logic                   block_ready,
   output logic [511:0]           block_data,
   output logic [NONCE_WIDTH-1:0] block_nonce,
   output logic                   done,
   output logic                   exhausted
);

   localparam int KL_W  = $clog2(MAX_KEY_BYTES + 1);
   localparam int KI_W  = $clog2(MAX_KEY_BYTES);
   localparam int CNT_W = $clog2(NONCE_DIGITS + 1);

   gen_state_t                state;
   logic [7:0]                key_mem [MAX_KEY_BYTES];
   logic [KL_W-1:0]           key_len;
   logic [4*NONCE_DIGITS-1:0] digits;
   logic [CNT_W-1:0]          digit_count;
   logic                      overflow;
   logic                      accept;
   logic                      key_wr;
   logic [7:0]                msg_len;
   md5_block_t                blk;

   assign accept  = block_valid && block_ready;
   assign key_wr  = key_valid && key_ready;
   assign msg_len = 8'(key_len) + 8'(digit_count);

   bcd_counter #(
      .NONCE_DIGITS(NONCE_DIGITS)
   ) u_bcd (
      .clk        (clk),
      .reset      (reset),
      .inc        (accept),
      .digits     (digits),
      .digit_count(digit_count),
      .overflow   (overflow)
   );

   // Key contents are only meaningful below key_len, so the array needs no reset.
   always_ff @(posedge clk) begin
      if (key_wr && (key_len < KL_W'(MAX_KEY_BYTES))) begin
         key_mem[key_len[KI_W-1:0]] <= key_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= GEN_IDLE;
         key_ready   <= 1'b1;
         block_valid <= 1'b0;
         done        <= 1'b0;
         exhausted   <= 1'b0;
         key_len     <= '0;
         block_nonce <= NONCE_WIDTH'(1);
      end else begin
         case (state)
            GEN_IDLE: begin
               if (key_valid) begin
                  if (key_len < KL_W'(MAX_KEY_BYTES)) begin
                     key_len <= key_len + 1'b1;
                  end
                  if (key_last) begin
                     state       <= GEN_RUN;
                     key_ready   <= 1'b0;
                     block_valid <= 1'b1;
                  end
               end
            end
            GEN_RUN: begin
               if (accept) begin
                  block_nonce <= block_nonce + 1'b1;
               end
               // The all-nines block still counts as accepted before halting.
               if (stop || (accept && overflow)) begin
                  state       <= GEN_DONE;
                  block_valid <= 1'b0;
                  done        <= 1'b1;
                  exhausted   <= accept && overflow;
               end
            end
            GEN_DONE: begin
            end
            default: begin
               state <= GEN_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      blk = '0;
      for (int k = 0; k < MAX_KEY_BYTES; k++) begin
         if (k < int'(key_len)) begin
            blk[8*k +: 8] = key_mem[k];
         end
      end
      // Digits follow the key, most significant first; pad byte right after.
      for (int p = 0; p < MD5_LEN_OFFSET; p++) begin
         if ((p >= int'(key_len)) && (p < int'(msg_len))) begin
            blk[8*p +: 8] = bcd_to_ascii(digits[4*(int'(msg_len) - 1 - p) +: 4]);
         end else if (p == int'(msg_len)) begin
            blk[8*p +: 8] = MD5_PAD_BYTE;
         end
      end
      blk[8*MD5_BLOCK_BYTES-1 -: 64] = {53'b0, msg_len, 3'b000};
   end

   assign block_data = blk;

endmodule
